// File: rtl/dsp_sample_reader_if.sv
// DSP link and sample-output bundle: serial request/data lines plus the parallel volume word.
// The reader side drives the request and the sample outputs, and receives the serial data.
interface dsp_sample_reader_if #(
  parameter int SAMPLE_BITS = 8
);
  logic                   DSPingang;
  logic                   DSPctrl;
  logic [SAMPLE_BITS-1:0] huil_vol;
  logic                   vol_valid;
  logic                   link_err;

  modport master (
    input  DSPingang,
    output DSPctrl,
    output huil_vol,
    output vol_valid,
    output link_err
  );

  modport slave (
    output DSPingang,
    input  DSPctrl,
    input  huil_vol,
    input  vol_valid,
    input  link_err
  );
endinterface

// File: rtl/dsp_sample_reader.sv
// Polls the DSP with a one-bit request and deserialises its framed sample (start, MSB-first data, stop).
// Output is strobe-only with no backpressure: vol_valid/link_err pulse one cycle after the stop/error decision.
module dsp_sample_reader #(
  parameter int SAMPLE_BITS  = 8,
  parameter int BIT_DIV      = 50,
  parameter int POLL_PERIOD  = 50000,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  dsp_sample_reader_if.master  bus
);

  localparam int TO_CYC  = TIMEOUT_BITS * BIT_DIV;
  localparam int CNT_MAX = (POLL_PERIOD > TO_CYC) ? POLL_PERIOD : TO_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(SAMPLE_BITS + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_PERIOD - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_CYC - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BITS_LAST = BW'(SAMPLE_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_START,
    HALF,
    DATA,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] vol_q, vol_d;
  logic                   ctrl_q, ctrl_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   din_s;

  assign din_s = sync2_q;

  // One shared counter serves poll, request, timeout and bit timing; it is
  // cleared on every state change so each phase starts counting from zero.
  always_comb begin
    sync1_d = bus.DSPingang;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    vol_d   = vol_q;
    ctrl_d  = ctrl_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (cnt_q == POLL_LAST) begin
            cnt_d   = '0;
            ctrl_d  = 1'b1;
            state_d = REQ;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      REQ: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          ctrl_d  = 1'b0;
          state_d = WAIT_START;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_START: begin
        // A start bit on the final allowed cycle wins over the timeout.
        if (!din_s) begin
          cnt_d   = '0;
          state_d = HALF;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HALF: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (din_s) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[SAMPLE_BITS-2:0], din_s};
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BITS_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (din_s) begin
            vol_d = shift_q;
            vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ctrl_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vol_q   <= '0;
      ctrl_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vol_q   <= vol_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.DSPctrl   = ctrl_q;
  assign bus.huil_vol  = vol_q;
  assign bus.vol_valid = vld_q;
  assign bus.link_err  = err_q;

endmodule
